// File: rtl/crossbar_pkg.sv
// Shared constants and state type for the 4x4 4-bit crossbar and its control sequencer.
package crossbar_pkg;

    localparam int unsigned CTL_W       = 5;
    localparam int unsigned DATA_W      = 4;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_DWELL_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } seq_state_e;

endpackage

// File: rtl/crossbar_ctl_table.sv
// Programmable table of crossbar control words and dwell counts.
// One synchronous write port, one combinational read port; cleared on reset.
module crossbar_ctl_table #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CTL_W   = 5,
    parameter int unsigned DWELL_W = 4,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [CTL_W-1:0]   wr_ctl,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [CTL_W-1:0]   rd_ctl,
    output logic [DWELL_W-1:0] rd_dwell
);

    logic [CTL_W-1:0]   ctl_q   [DEPTH];
    logic [DWELL_W-1:0] dwell_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctl_q[i]   <= '0;
                dwell_q[i] <= '0;
            end
        end else if (wr_en) begin
            ctl_q[wr_addr]   <= wr_ctl;
            dwell_q[wr_addr] <= wr_dwell;
        end
    end

    // Reads see pre-edge contents, so a same-edge write lands on the next visit.
    assign rd_ctl   = ctl_q[rd_addr];
    assign rd_dwell = dwell_q[rd_addr];

endmodule

// File: rtl/crossbar_ctl_sequencer.sv
// Steps through the control table, holding each entry for dwell+1 cycles and
// driving the crossbar control word from a register; single-pass or looping.
module crossbar_ctl_sequencer
    import crossbar_pkg::*;
#(
    parameter int unsigned DEPTH   = crossbar_pkg::DEF_DEPTH,
    parameter int unsigned CTL_W   = crossbar_pkg::CTL_W,
    parameter int unsigned DWELL_W = crossbar_pkg::DEF_DWELL_W,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [CTL_W-1:0]   wr_ctl,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    output logic [CTL_W-1:0]   control,
    output logic               active,
    output logic [IDX_W-1:0]   idx,
    output logic               wrap,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    seq_state_e         state_q;
    logic [CTL_W-1:0]   control_q;
    logic               active_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wrap_q;
    logic               done_q;
    logic [DWELL_W-1:0] cnt_q;

    logic [IDX_W-1:0]   rd_addr;
    logic [CTL_W-1:0]   rd_ctl;
    logic [DWELL_W-1:0] rd_dwell;

    crossbar_ctl_table #(
        .DEPTH   (DEPTH),
        .CTL_W   (CTL_W),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ctl   (wr_ctl),
        .wr_dwell (wr_dwell),
        .rd_addr  (rd_addr),
        .rd_ctl   (rd_ctl),
        .rd_dwell (rd_dwell)
    );

    // Address of the entry loaded on the coming edge: next entry when advancing, else entry 0.
    always_comb begin
        rd_addr = '0;
        if (state_q == RUN && cnt_q == '0 && idx_q != LAST_IDX) begin
            rd_addr = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            control_q <= '0;
            active_q  <= 1'b0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q   <= RUN;
                        active_q  <= 1'b1;
                        idx_q     <= '0;
                        control_q <= rd_ctl;
                        cnt_q     <= rd_dwell;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        active_q  <= 1'b0;
                        idx_q     <= '0;
                        control_q <= '0;
                        cnt_q     <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_q != LAST_IDX) begin
                        idx_q     <= rd_addr;
                        control_q <= rd_ctl;
                        cnt_q     <= rd_dwell;
                    end else begin
                        wrap_q <= 1'b1;
                        idx_q  <= '0;
                        if (loop) begin
                            control_q <= rd_ctl;
                            cnt_q     <= rd_dwell;
                        end else begin
                            state_q   <= IDLE;
                            active_q  <= 1'b0;
                            control_q <= '0;
                            cnt_q     <= '0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign control = control_q;
    assign active  = active_q;
    assign idx     = idx_q;
    assign wrap    = wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_crossbar_ctl_sequencer.sv
// Directed bench for crossbar_ctl_sequencer; checks outputs on the falling edge.
module tb_crossbar_ctl_sequencer;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_ctl;
    logic [3:0] wr_dwell;
    logic       start;
    logic       stop;
    logic       loop;
    logic [4:0] control;
    logic       active;
    logic [1:0] idx;
    logic       wrap;
    logic       done;

    int vecs;
    int errs;

    // Single-pass / loop pattern for table {01/0, 0A/1, 15/2, 1F/0}
    logic [4:0] pat_ctl [7];
    logic [1:0] pat_idx [7];

    crossbar_ctl_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ctl   (wr_ctl),
        .wr_dwell (wr_dwell),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .control  (control),
        .active   (active),
        .idx      (idx),
        .wrap     (wrap),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] c, input logic a,
                           input logic [1:0] i, input logic w, input logic d);
        chk({tag, ".control"}, 32'(control), 32'(c));
        chk({tag, ".active"},  32'(active),  32'(a));
        chk({tag, ".idx"},     32'(idx),     32'(i));
        chk({tag, ".wrap"},    32'(wrap),    32'(w));
        chk({tag, ".done"},    32'(done),    32'(d));
    endtask

    task automatic wr(input logic [1:0] a, input logic [4:0] c, input logic [3:0] d);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_ctl   = c;
        wr_dwell = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_base_table();
        wr(2'd0, 5'h01, 4'd0);
        wr(2'd1, 5'h0A, 4'd1);
        wr(2'd2, 5'h15, 4'd2);
        wr(2'd3, 5'h1F, 4'd0);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        pat_ctl = '{5'h01, 5'h0A, 5'h0A, 5'h15, 5'h15, 5'h15, 5'h1F};
        pat_idx = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_ctl = '0; wr_dwell = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        #3;
        chk_all("reset", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single pass
        load_base_table();
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk_all($sformatf("t1.c%0d", i), pat_ctl[i], 1'b1, pat_idx[i], 1'b0, 1'b0);
            tick();
        end
        chk_all("t1.end", 5'h00, 1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        chk_all("t1.idle", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // 2: looping, stop on a 15 cycle
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            chk_all($sformatf("t2.c%0d", i), pat_ctl[i % 7], 1'b1, pat_idx[i % 7],
                    (i % 7 == 0) && (i > 0), 1'b0);
            if (i < 17) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t2.stop", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // 3: start+stop in IDLE, then stop on the last entry with loop=1
        start = 1'b1; stop = 1'b1;
        tick();
        chk_all("t3.both", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        stop = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_all("t3.last", 5'h1F, 1'b1, 2'd3, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t3.stop", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t3.after", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // 4a: rewrite entry 0 while idx=2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_all("t4a.idx2", 5'h15, 1'b1, 2'd2, 1'b0, 1'b0);
        wr(2'd0, 5'h07, 4'd0);
        for (int i = 0; i < 3; i++) tick();
        chk_all("t4a.revisit", 5'h07, 1'b1, 2'd0, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // 4b: write entry 0 on the same edge as start
        wr(2'd0, 5'h01, 4'd0);
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd0; wr_ctl = 5'h07; wr_dwell = 4'd0;
        tick();
        start = 1'b0; wr_en = 1'b0;
        chk_all("t4b.old", 5'h01, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk_all("t4b.new", 5'h07, 1'b1, 2'd0, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // 5: async reset mid-dwell on entry 2, table cleared afterwards
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_all("t5.mid", 5'h15, 1'b1, 2'd2, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_all("t5.async", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t5.e0", 5'h00, 1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t5.e1", 5'h00, 1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("t5.e3", 5'h00, 1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        chk_all("t5.end", 5'h00, 1'b0, 2'd0, 1'b1, 1'b1);

        // 6: all-zero dwell, looping
        wr(2'd0, 5'h01, 4'd0);
        wr(2'd1, 5'h02, 4'd0);
        wr(2'd2, 5'h03, 4'd0);
        wr(2'd3, 5'h04, 4'd0);
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_all($sformatf("t6.c%0d", i), 5'((i % 4) + 1), 1'b1, 2'(i % 4),
                    (i % 4 == 0) && (i > 0), 1'b0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t6.stop", 5'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/crossbar_ctl_sequencer.md
Name: crossbar_ctl_sequencer

Overview:
Upstream control stage for the 4x4 4-bit crossbar. It holds a small programmable table of 5-bit crossbar control words, each with a dwell count. On start, it steps through the table and drives the crossbar's 5-bit control input from a register. It either loops continuously or makes a single pass, then returns to idle with a done pulse.

Parameters:
DEPTH, 4, number of table entries; a power of two, at least 2
CTL_W, 5, control word width; matches the crossbar control input
DWELL_W, 4, dwell field width; an entry is held for dwell+1 cycles

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  table write strobe
wr_addr  input  log2(DEPTH)  table entry to write
wr_ctl  input  CTL_W  control word to store
wr_dwell  input  DWELL_W  dwell value to store
start  input  1  begin sequencing from entry 0 (level-sampled)
stop  input  1  abort sequencing and return to idle
loop  input  1  1 = wrap continuously; 0 = single pass
control  output  CTL_W  registered control word to the crossbar
active  output  1  high while in RUN
idx  output  log2(DEPTH)  index of the entry currently driven
wrap  output  1  one-cycle pulse when the last entry completes
done  output  1  one-cycle pulse when a single pass ends

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; control=0, active=0, idx=0, wrap=0, done=0.
  - Dwell counter=0; all table entries (ctl and dwell) cleared to 0.
- Table writes:
  - A write commits on the rising edge when wr_en=1, in any state.
  - A load reads the pre-edge table contents. If a write and a load hit the same entry on the same edge, the old value is driven; the new value takes effect on the next visit.
- States are IDLE and RUN only.
- IDLE -> RUN: start=1 and stop=0 at edge N.
  - After edge N: active=1, idx=0, control=tbl_ctl[0], cnt=tbl_dwell[0].
- RUN, holding an entry:
  - If cnt!=0: cnt decrements; control and idx hold.
  - Result: entry i is driven for exactly tbl_dwell[i]+1 cycles.
- RUN, advancing:
  - If cnt==0 and idx<DEPTH-1: idx+1 is loaded (control and cnt from the table).
  - If cnt==0 and idx==DEPTH-1:
    - wrap pulses for one cycle, aligned with the cycle in which the next state appears on the outputs.
    - loop=1: idx=0 and entry 0 reloads, with no gap cycle.
    - loop=0: go to IDLE; control=0, active=0, idx=0; done pulses in that same cycle.
    - wrap and done may both be high on single-pass completion.
- stop=1 in RUN:
  - Next edge goes to IDLE with control=0, active=0, idx=0.
  - No wrap or done pulse, even if the edge coincides with the last entry.
  - stop has priority over start and over advancing.
- start=1 while in RUN is ignored; there is no restart. start held high in IDLE after a single pass restarts on the next edge.
- loop is sampled only at the last-entry decision point. Changing it mid-pass affects only that decision.
- dwell=0 gives a 1-cycle entry. A table of all zeros with loop=1 cycles one entry per clock.
- Reset mid-RUN aborts immediately; all outputs drop to their reset values asynchronously.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package crossbar_pkg:
  - CTL_W=5 and DATA_W=4 constants, shared with the crossbar.
  - DEPTH and DWELL_W defaults.
  - State enum {IDLE, RUN}.
- Sub-module crossbar_ctl_table:
  - DEPTH x (CTL_W+DWELL_W) register file.
  - One synchronous write port, one combinational read port indexed by next-idx.
  - Asynchronous clear on rst_n.
- The FSM, dwell counter and output registers live in the top module.

Test Plan:
1. Write the table {5'h01/0, 5'h0A/1, 5'h15/2, 5'h1F/0}, then start with loop=0 -> control sequence 01; 0A,0A; 15,15,15; 1F; then 0. done and wrap pulse together in the first cycle with control=0; active is high for exactly 7 cycles.
2. Same table with loop=1 -> after 1F, 01 follows immediately with no gap; wrap pulses every 7 cycles; done never pulses; stop asserted in a 15 cycle -> control=0 and active=0 after the next edge.
3. stop and start high together in IDLE -> remains IDLE, control=0. stop on the 1F cycle with loop=1 -> IDLE, no wrap pulse.
4. In RUN, write entry 0 to 5'h07 while idx=2 -> 5'h07 is driven on the next visit. Write entry 0 on the same edge as start -> old 5'h01 is driven in this pass and 5'h07 in the next pass.
5. rst_n dropped asynchronously mid-dwell on entry 2 -> control=0, active=0, idx=0 before the next clock edge. After release, start -> control=0 because the table was cleared.
6. All-zero dwell, loop=1, table {1,2,3,4} -> control 1,2,3,4,1,... changing every clock; wrap is high every 4th cycle.
